// File: rtl/sp_ctrl.sv
// Stack-pointer controller: push/pop/load of a bounded, downward-growing stack
// pointer, with a sticky fault state that holds until clr_fault.

module sp_dec #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic             borrow
);
    logic [WIDTH:0] b;

    // Ripple-borrow chain; borrow out is high only when a is zero.
    assign b[0] = 1'b1;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y[gi]   = a[gi] ^ b[gi];
        assign b[gi+1] = ~a[gi] & b[gi];
    end
    assign borrow = b[WIDTH];
endmodule

module sp_inc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic             carry
);
    logic [WIDTH:0] c;

    assign c[0] = 1'b1;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y[gi]   = a[gi] ^ c[gi];
        assign c[gi+1] = a[gi] & c[gi];
    end
    assign carry = c[WIDTH];
endmodule

module sp_ctrl #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] SP_INIT  = 32'h0000_03FF,
    parameter logic [WIDTH-1:0] SP_LIMIT = 32'h0000_0300
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             clr_fault,
    output logic [WIDTH-1:0] sp,
    output logic [WIDTH-1:0] depth,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_code
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_OVER  = 2'b01;
    localparam logic [1:0] FC_UNDER = 2'b10;
    localparam logic [1:0] FC_LOAD  = 2'b11;

    logic [0:0]       state_reg, state_next;
    logic [WIDTH-1:0] sp_reg, sp_next;
    logic [WIDTH-1:0] depth_reg, depth_next;
    logic             done_reg, done_next;
    logic             fault_reg, fault_next;
    logic [1:0]       code_reg, code_next;

    logic [WIDTH-1:0] dec_val, inc_val;
    logic             dec_borrow, inc_carry;

    sp_dec #(.WIDTH(WIDTH)) u_dec (
        .a      (sp_reg),
        .y      (dec_val),
        .borrow (dec_borrow)
    );

    sp_inc #(.WIDTH(WIDTH)) u_inc (
        .a     (sp_reg),
        .y     (inc_val),
        .carry (inc_carry)
    );

    always_comb begin
        state_next = state_reg;
        sp_next    = sp_reg;
        done_next  = 1'b0;
        fault_next = fault_reg;
        code_next  = code_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ld) begin
                    if (ld_val < SP_LIMIT || ld_val > SP_INIT) begin
                        state_next = ST_FAULT;
                        fault_next = 1'b1;
                        code_next  = FC_LOAD;
                    end else begin
                        sp_next   = ld_val;
                        done_next = 1'b1;
                    end
                end else if (push && pop) begin
                    // Simultaneous push and pop cancel out but still complete.
                    done_next = 1'b1;
                end else if (push) begin
                    if (sp_reg <= SP_LIMIT || dec_borrow) begin
                        state_next = ST_FAULT;
                        fault_next = 1'b1;
                        code_next  = FC_OVER;
                    end else begin
                        sp_next   = dec_val;
                        done_next = 1'b1;
                    end
                end else if (pop) begin
                    if (sp_reg >= SP_INIT || inc_carry) begin
                        state_next = ST_FAULT;
                        fault_next = 1'b1;
                        code_next  = FC_UNDER;
                    end else begin
                        sp_next   = inc_val;
                        done_next = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                // Requests arriving with clr_fault are intentionally dropped.
                if (clr_fault) begin
                    state_next = ST_IDLE;
                    fault_next = 1'b0;
                    code_next  = FC_NONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        depth_next = SP_INIT - sp_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sp_reg    <= SP_INIT;
            depth_reg <= '0;
            done_reg  <= 1'b0;
            fault_reg <= 1'b0;
            code_reg  <= FC_NONE;
        end else begin
            state_reg <= state_next;
            sp_reg    <= sp_next;
            depth_reg <= depth_next;
            done_reg  <= done_next;
            fault_reg <= fault_next;
            code_reg  <= code_next;
        end
    end

    assign sp         = sp_reg;
    assign depth      = depth_reg;
    assign done       = done_reg;
    assign fault      = fault_reg;
    assign fault_code = code_reg;
endmodule

// File: tb/tb_sp_ctrl.sv
// Directed bench for sp_ctrl: a table of single-cycle requests with expected
// outputs, followed by hand-written reset and post-reset fault sequences.

module tb_sp_ctrl;
    logic        clk;
    logic        rst_n;
    logic        push;
    logic        pop;
    logic        ld;
    logic [31:0] ld_val;
    logic        clr_fault;
    logic [31:0] sp;
    logic [31:0] depth;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        push;
        logic        pop;
        logic        ld;
        logic [31:0] ld_val;
        logic        clr;
        logic [31:0] sp;
        logic [31:0] depth;
        logic        done;
        logic        fault;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[$];

    sp_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .ld         (ld),
        .ld_val     (ld_val),
        .clr_fault  (clr_fault),
        .sp         (sp),
        .depth      (depth),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic p, input logic po, input logic l,
                                input logic [31:0] v, input logic c,
                                input logic [31:0] s, input logic [31:0] d,
                                input logic dn, input logic f, input logic [1:0] fc);
        vec_t r;
        r.push = p; r.pop = po; r.ld = l; r.ld_val = v; r.clr = c;
        r.sp = s; r.depth = d; r.done = dn; r.fault = f; r.code = fc;
        return r;
    endfunction

    // Drive a request at the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic p, input logic po, input logic l,
                        input logic [31:0] v, input logic c);
        @(negedge clk);
        push = p; pop = po; ld = l; ld_val = v; clr_fault = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; ld = 1'b0; clr_fault = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] s, input logic [31:0] d,
                         input logic dn, input logic f, input logic [1:0] fc);
        n_cmp++;
        if (sp !== s || depth !== d || done !== dn || fault !== f || fault_code !== fc) begin
            n_bad++;
            $display("FAIL %s: got sp=%h depth=%h done=%b fault=%b code=%b, want sp=%h depth=%h done=%b fault=%b code=%b",
                     name, sp, depth, done, fault, fault_code, s, d, dn, f, fc);
        end else begin
            $display("ok   %s: sp=%h depth=%h done=%b fault=%b code=%b",
                     name, sp, depth, done, fault, fault_code);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        push = 1'b0; pop = 1'b0; ld = 1'b0; ld_val = '0; clr_fault = 1'b0;
        rst_n = 1'b0;

        //            push pop ld  ld_val        clr   sp            depth         dn   f    code
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h3FE, 32'h01, 1, 0, 2'b00)); // push 1
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h3FD, 32'h02, 1, 0, 2'b00)); // push 2
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h3FC, 32'h03, 1, 0, 2'b00)); // push 3
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h3FC, 32'h03, 0, 0, 2'b00)); // done drops
        vecs.push_back(mk(0, 0, 1, 32'h380, 0, 32'h380, 32'h7F, 1, 0, 2'b00)); // ld 380
        vecs.push_back(mk(1, 1, 0, 32'h0,   0, 32'h380, 32'h7F, 1, 0, 2'b00)); // push+pop
        vecs.push_back(mk(0, 0, 1, 32'h300, 0, 32'h300, 32'hFF, 1, 0, 2'b00)); // ld limit
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h300, 32'hFF, 0, 1, 2'b01)); // overflow
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h300, 32'hFF, 0, 1, 2'b01)); // push ignored
        vecs.push_back(mk(0, 0, 1, 32'h3A0, 0, 32'h300, 32'hFF, 0, 1, 2'b01)); // ld ignored
        vecs.push_back(mk(0, 1, 0, 32'h0,   1, 32'h300, 32'hFF, 0, 0, 2'b00)); // clr, pop dropped
        vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h301, 32'hFE, 1, 0, 2'b00)); // pop
        vecs.push_back(mk(0, 0, 1, 32'h500, 0, 32'h301, 32'hFE, 0, 1, 2'b11)); // bad ld high
        vecs.push_back(mk(0, 0, 0, 32'h0,   1, 32'h301, 32'hFE, 0, 0, 2'b00)); // clr
        vecs.push_back(mk(1, 0, 1, 32'h350, 0, 32'h350, 32'hAF, 1, 0, 2'b00)); // ld beats push
        vecs.push_back(mk(0, 0, 1, 32'h2FF, 0, 32'h350, 32'hAF, 0, 1, 2'b11)); // bad ld low
        vecs.push_back(mk(0, 0, 0, 32'h0,   1, 32'h350, 32'hAF, 0, 0, 2'b00)); // clr
        vecs.push_back(mk(0, 0, 1, 32'h3FF, 0, 32'h3FF, 32'h00, 1, 0, 2'b00)); // ld init
        vecs.push_back(mk(0, 0, 0, 32'h0,   1, 32'h3FF, 32'h00, 0, 0, 2'b00)); // clr in idle
        vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h3FF, 32'h00, 0, 1, 2'b10)); // underflow
        vecs.push_back(mk(0, 0, 0, 32'h0,   1, 32'h3FF, 32'h00, 0, 0, 2'b00)); // clr
        vecs.push_back(mk(0, 0, 1, 32'h300, 0, 32'h300, 32'hFF, 1, 0, 2'b00)); // ld limit
        vecs.push_back(mk(1, 1, 0, 32'h0,   0, 32'h300, 32'hFF, 1, 0, 2'b00)); // push+pop at limit
        vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h301, 32'hFE, 1, 0, 2'b00)); // pop off limit

        #12;
        check("reset_hold", 32'h3FF, 32'h0, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].ld, vecs[i].ld_val, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].sp, vecs[i].depth,
                  vecs[i].done, vecs[i].fault, vecs[i].code);
        end

        // Pop straight out of reset underflows; pushes stay ignored until clr_fault.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step(0, 1, 0, 32'h0, 0);
        check("rst_pop_uflow", 32'h3FF, 32'h0, 1'b0, 1'b1, 2'b10);
        step(1, 0, 0, 32'h0, 0);
        check("uflow_push_ign", 32'h3FF, 32'h0, 1'b0, 1'b1, 2'b10);
        step(0, 0, 0, 32'h0, 1);
        check("uflow_clr", 32'h3FF, 32'h0, 1'b0, 1'b0, 2'b00);
        step(1, 0, 0, 32'h0, 0);
        check("post_clr_push", 32'h3FE, 32'h1, 1'b1, 1'b0, 2'b00);

        // Half-cycle reset with a push in flight after two pushes.
        step(1, 0, 0, 32'h0, 0);
        check("pre_rst_push", 32'h3FD, 32'h2, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        push = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'h3FF, 32'h0, 1'b0, 1'b0, 2'b00);
        push = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release", 32'h3FF, 32'h0, 1'b0, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        check("rst_no_done", 32'h3FF, 32'h0, 1'b0, 1'b0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
